// File: rtl/mult32_seq_ctrl_if.sv
// Handshake and result bus between the ALU control unit and the
// sequential multiplier.
interface mult32_seq_ctrl_if;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  // Control unit side: issues requests and observes results.
  modport master (
    output START, SIGNED, A, B,
    input  BUSY, DONE, HI, LO
  );

  // Multiplier side.
  modport slave (
    input  START, SIGNED, A, B,
    output BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/mult32_seq_ctrl.sv
// Sequential 32x32 multiplier (signed/unsigned) using one shared 33-bit
// add path iterated 32 times. Signed operands are converted to magnitudes
// up front and the product is negated at the end when the signs differ.
module mult32_seq_ctrl (
  input logic                CLK,
  input logic                RST,
  mult32_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic [31:0] mc_q;
  logic [63:0] p_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic [32:0] sum_d;
  logic [63:0] p_iter_d;
  logic [63:0] p_fix_d;
  logic [31:0] mc_init_d;
  logic [31:0] pl_init_d;
  logic        neg_init_d;

  // Datapath: operand magnitudes, shared add/shift step and final sign fix.
  always_comb begin
    mc_init_d  = (sgn_q & a_q[31]) ? (~a_q + 32'd1) : a_q;
    pl_init_d  = (sgn_q & b_q[31]) ? (~b_q + 32'd1) : b_q;
    neg_init_d = sgn_q & (a_q[31] ^ b_q[31]);
    sum_d      = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mc_q} : 33'd0);
    p_iter_d   = {sum_d, p_q[31:1]};
    p_fix_d    = neg_q ? (~p_q + 64'd1) : p_q;
  end

  // Control FSM with registered BUSY/DONE and the HI/LO result registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      mc_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            sgn_q   <= bus.SIGNED;
            state_q <= S_PREP;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_PREP: begin
          mc_q    <= mc_init_d;
          p_q     <= {32'd0, pl_init_d};
          neg_q   <= neg_init_d;
          cnt_q   <= '0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          p_q   <= p_iter_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          p_q     <= p_fix_d;
          hi_q    <= p_fix_d[63:32];
          lo_q    <= p_fix_d[31:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed bench for mult32_seq_ctrl: a vector table of products plus
// hand-written sequences for busy protection, reset abort and back-to-back.
module tb_mult32_seq_ctrl;

  logic CLK;
  logic RST;
  int unsigned total;
  int unsigned bad;

  mult32_seq_ctrl_if bus ();

  mult32_seq_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, then wait for DONE. lat counts edges after the
  // sampling edge up to the DONE edge; busy_n counts cycles BUSY was seen.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_n, output logic ok);
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.SIGNED = sgn;
    bus.A      = a;
    bus.B      = b;
    @(posedge CLK);
    #1;
    bus.START  = 1'b0;
    bus.A      = 32'hDEAD_BEEF;
    bus.B      = 32'hCAFE_F00D;
    bus.SIGNED = ~sgn;
    lat    = 0;
    busy_n = bus.BUSY ? 1 : 0;
    ok     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      lat++;
      if (bus.BUSY && bus.DONE) begin
        chk("busy_and_done", 64'd1, 64'd0);
      end
      if (bus.DONE) begin
        ok = 1'b1;
        break;
      end
      if (bus.BUSY) busy_n++;
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int busy_n;
    logic ok;
    int dones;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    total = 0;
    bad   = 0;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[7] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[8] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};

    bus.START  = 1'b0;
    bus.SIGNED = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    RST        = 1'b0;
    #1;
    chk("reset_busy", {63'd0, bus.BUSY}, 64'd0);
    chk("reset_done", {63'd0, bus.DONE}, 64'd0);
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // Product table; each entry also checks latency and BUSY length.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_n, ok);
      chk($sformatf("vec%0d_hilo", i), {bus.HI, bus.LO}, {vecs[i].hi, vecs[i].lo});
      if (i < 2) begin
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
        chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd34);
      end
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_done_pulse_ends", i), {63'd0, bus.DONE}, 64'd0);
    end

    // HI/LO hold through idle cycles.
    hold_hi = bus.HI;
    hold_lo = bus.LO;
    repeat (7) @(posedge CLK);
    #1;
    chk("idle_hold_hilo", {bus.HI, bus.LO}, {hold_hi, hold_lo});

    // Busy protection: a second START mid-operation is dropped.
    @(negedge CLK);
    bus.START = 1'b1; bus.SIGNED = 1'b0; bus.A = 32'd7; bus.B = 32'd6;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (9) @(negedge CLK);
    bus.START = 1'b1; bus.A = 32'd2; bus.B = 32'd2;
    @(negedge CLK);
    bus.START = 1'b0;
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE) begin
        dones++;
        chk("busyprot_hilo", {bus.HI, bus.LO}, 64'd42);
      end
    end
    chk("busyprot_done_count", 64'(dones), 64'd1);

    // Reset abort.
    @(negedge CLK);
    bus.START = 1'b1; bus.SIGNED = 1'b0; bus.A = 32'd5; bus.B = 32'd5;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (14) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.BUSY}, 64'd0);
    chk("abort_done", {63'd0, bus.DONE}, 64'd0);
    chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE || bus.BUSY) dones++;
    end
    chk("abort_no_activity", 64'(dones), 64'd0);
    do_op(1'b0, 32'd3, 32'd4, lat, busy_n, ok);
    chk("after_abort_hilo", {bus.HI, bus.LO}, 64'd12);
    chk("after_abort_latency", 64'(lat), 64'd34);

    // Back-to-back with START held through the DONE cycle.
    @(negedge CLK);
    bus.START = 1'b1; bus.SIGNED = 1'b0; bus.A = 32'h0001_0000; bus.B = 32'h0001_0000;
    @(posedge CLK);
    #1;
    bus.A = 32'd0; bus.B = 32'h1234;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      lat++;
      if (bus.DONE) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_first_seen", {63'd0, ok}, 64'd1);
    chk("b2b_first_latency", 64'(lat), 64'd34);
    chk("b2b_first_hilo", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    chk("b2b_restart_busy", {63'd0, bus.BUSY}, 64'd1);
    chk("b2b_hold_during_second", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      lat++;
      if (bus.DONE) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_second_seen", {63'd0, ok}, 64'd1);
    chk("b2b_second_gap", 64'(lat), 64'd35);
    chk("b2b_second_hilo", {bus.HI, bus.LO}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
